// File: rtl/dcache_tag_arbiter.sv
// +-----------------------------------------------------------------------------+
// | dcache_tag_arbiter: round-robin tag/data SRAM arbiter, S0 issue / S1 compare |
// | Optional lock feature: DCACHE_TAG_ARB_LOCK_EN          Revision: 1.0        |
// +-----------------------------------------------------------------------------+
`default_nettype none

module dcache_tag_arbiter #(
  parameter int NR_PORTS   = 3,
  parameter int ADDR_WIDTH = 12,
  parameter int TAG_WIDTH  = 44,
  parameter int SET_ASSOC  = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NR_PORTS-1:0]             req_i,
  input  logic [NR_PORTS-1:0]             we_i,
  input  logic [NR_PORTS*ADDR_WIDTH-1:0]  addr_i,
  input  logic [NR_PORTS*TAG_WIDTH-1:0]   tag_i,
  input  logic [NR_PORTS-1:0]             kill_i,
`ifdef DCACHE_TAG_ARB_LOCK_EN
  input  logic [NR_PORTS-1:0]             lock_i,
`endif
  output logic [NR_PORTS-1:0]             gnt_o,
  output logic [NR_PORTS-1:0]             rvalid_o,
  output logic                            hit_o,
  output logic [SET_ASSOC-1:0]            hit_way_o,
  input  logic                            stall_i,
  output logic [SET_ASSOC-1:0]            sram_req_o,
  output logic [ADDR_WIDTH-1:0]           sram_addr_o,
  output logic                            sram_we_o,
  input  logic [SET_ASSOC-1:0]            sram_way_i,
  input  logic [SET_ASSOC*TAG_WIDTH-1:0]  sram_tag_i,
  input  logic [SET_ASSOC-1:0]            sram_valid_i
);

  localparam int PTR_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

  logic [PTR_W-1:0]    ptr_q;
  logic [PTR_W-1:0]    winner;
  logic [PTR_W-1:0]    next_ptr;
  logic                found;
  logic                grant;
  logic                win_we;
  logic                s1_valid_q;
  logic [NR_PORTS-1:0] s1_id_q;
  logic [TAG_WIDTH-1:0] sel_tag;
  logic                s1_live;

`ifdef DCACHE_TAG_ARB_LOCK_EN
  logic                lock_q;
  logic [PTR_W-1:0]    lock_id_q;
`endif

  // Round-robin search from the pointer; an active lock overrides it
  always_comb begin
    int unsigned idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NR_PORTS; i++) begin
      idx = (int'(ptr_q) + i) % NR_PORTS;
      if (!found && req_i[idx]) begin
        found  = 1'b1;
        winner = PTR_W'(idx);
      end
    end
`ifdef DCACHE_TAG_ARB_LOCK_EN
    if (lock_q) begin
      found  = req_i[lock_id_q];
      winner = lock_id_q;
    end
`endif
  end

  // Reset gates S0 so the combinational outputs are quiet while rst_ni is low
  assign grant    = found & ~stall_i & rst_ni;
  assign win_we   = we_i[winner];
  assign next_ptr = (winner == PTR_W'(NR_PORTS - 1)) ? '0 : winner + PTR_W'(1);

  always_comb begin
    gnt_o       = '0;
    sram_addr_o = '0;
    if (grant) gnt_o[winner] = 1'b1;
    for (int p = 0; p < NR_PORTS; p++) begin
      if (gnt_o[p]) sram_addr_o = sram_addr_o | addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  assign sram_we_o  = grant & win_we;
  assign sram_req_o = !grant ? '0 : (win_we ? sram_way_i : '1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
`ifdef DCACHE_TAG_ARB_LOCK_EN
      lock_q     <= 1'b0;
      lock_id_q  <= '0;
`endif
    end else begin
      s1_valid_q <= grant & ~win_we;
      if (grant) begin
        s1_id_q <= gnt_o;
`ifdef DCACHE_TAG_ARB_LOCK_EN
        lock_q    <= lock_i[winner];
        lock_id_q <= winner;
        if (!lock_i[winner])
`endif
        ptr_q <= next_ptr;
      end
    end
  end

  // S1: the winner's tag arrives a cycle after its grant
  always_comb begin
    sel_tag = '0;
    for (int p = 0; p < NR_PORTS; p++) begin
      if (s1_id_q[p]) sel_tag = sel_tag | tag_i[p*TAG_WIDTH +: TAG_WIDTH];
    end
  end

  assign s1_live = s1_valid_q & ~(|(s1_id_q & kill_i));

  always_comb begin
    hit_way_o = '0;
    for (int j = 0; j < SET_ASSOC; j++) begin
      hit_way_o[j] = s1_live & sram_valid_i[j] &
                     (sel_tag == sram_tag_i[j*TAG_WIDTH +: TAG_WIDTH]);
    end
  end

  assign hit_o    = |hit_way_o;
  assign rvalid_o = s1_live ? s1_id_q : '0;

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (rst_ni && (|rvalid_o)) assert ($onehot0(hit_way_o));
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dcache_tag_arbiter.sv
// +-----------------------------------------------------------------------------+
// | tb_dcache_tag_arbiter: vector table plus lookup scoreboard for the arbiter  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_dcache_tag_arbiter;

  localparam int NP = 3;
  localparam int AW = 12;
  localparam int TW = 44;
  localparam int SA = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NP-1:0]   req, we, kill, gnt, rvalid;
  logic [NP*AW-1:0] addr;
  logic [NP*TW-1:0] tag;
  logic            hit, stall, sram_we;
  logic [SA-1:0]   hit_way, sram_req, sram_way, sram_valid;
  logic [AW-1:0]   sram_addr;
  logic [SA*TW-1:0] sram_tag;

  dcache_tag_arbiter #(.NR_PORTS(NP), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .SET_ASSOC(SA)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .tag_i(tag),
    .kill_i(kill), .gnt_o(gnt), .rvalid_o(rvalid), .hit_o(hit), .hit_way_o(hit_way),
    .stall_i(stall), .sram_req_o(sram_req), .sram_addr_o(sram_addr), .sram_we_o(sram_we),
    .sram_way_i(sram_way), .sram_tag_i(sram_tag), .sram_valid_i(sram_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] req, we, kill;
    logic       stall;
    logic [7:0] vld, way;
    logic [2:0] gnt;
    logic [7:0] sreq;
    logic       swe;
    logic [2:0] rv;
    logic [7:0] hw;
  } vec_t;

  typedef struct packed {
    logic [31:0] due;
    logic [2:0]  rv;
    logic [7:0]  hw;
  } sb_t;

  vec_t tbl[27];
  sb_t  sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  function automatic vec_t mk(logic [2:0] r, logic [2:0] w, logic [2:0] k, logic s,
                              logic [7:0] vl, logic [7:0] wy, logic [2:0] g,
                              logic [7:0] sr, logic swe, logic [2:0] rv, logic [7:0] hw);
    vec_t v;
    v.req = r; v.we = w; v.kill = k; v.stall = s; v.vld = vl; v.way = wy;
    v.gnt = g; v.sreq = sr; v.swe = swe; v.rv = rv; v.hw = hw;
    return v;
  endfunction

  function automatic logic [AW-1:0] addr_of(logic [2:0] g);
    case (g)
      3'b001:  return 12'h111;
      3'b010:  return 12'h222;
      3'b100:  return 12'h333;
      default: return 12'h000;
    endcase
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic run_cycle(vec_t v);
    sb_t e;
    @(posedge clk);
    #1;
    req = v.req; we = v.we; kill = v.kill; stall = v.stall;
    sram_valid = v.vld; sram_way = v.way;
    cyc++;
    @(negedge clk);
    chk("gnt", 64'(gnt), 64'(v.gnt));
    chk("sram_req", 64'(sram_req), 64'(v.sreq));
    chk("sram_we", 64'(sram_we), 64'(v.swe));
    chk("sram_addr", 64'(sram_addr), 64'(addr_of(v.gnt)));
    if (sbq.size() > 0 && sbq[0].due == 32'(cyc)) e = sbq.pop_front();
    else e = '{due: 32'(cyc), rv: 3'b000, hw: 8'h00};
    chk("rvalid", 64'(rvalid), 64'(e.rv));
    if (e.rv != 3'b000) begin
      chk("hit_way", 64'(hit_way), 64'(e.hw));
      chk("hit", 64'(hit), 64'(|e.hw));
    end else begin
      chk("hit_idle", 64'(hit), 64'h0);
    end
    if (v.gnt != 3'b000 && (v.gnt & v.we) == 3'b000)
      sbq.push_back('{due: 32'(cyc + 1), rv: v.rv, hw: v.hw});
  endtask

  initial begin
    // req, we, kill, stall, vld, way | gnt, sram_req, sram_we, rvalid-next, hit_way-next
    tbl[0]  = mk(3'b111, 3'b000, 3'b000, 0, 8'hFF, 8'h00, 3'b001, 8'hFF, 0, 3'b001, 8'h02);
    tbl[1]  = mk(3'b111, 3'b000, 3'b000, 0, 8'hFF, 8'h00, 3'b010, 8'hFF, 0, 3'b010, 8'h08);
    tbl[2]  = mk(3'b111, 3'b000, 3'b000, 0, 8'hFF, 8'h00, 3'b100, 8'hFF, 0, 3'b100, 8'h20);
    tbl[3]  = mk(3'b111, 3'b000, 3'b000, 0, 8'hFF, 8'h00, 3'b001, 8'hFF, 0, 3'b001, 8'h02);
    tbl[4]  = mk(3'b111, 3'b000, 3'b000, 0, 8'hFF, 8'h00, 3'b010, 8'hFF, 0, 3'b010, 8'h08);
    tbl[5]  = mk(3'b111, 3'b000, 3'b000, 0, 8'hFF, 8'h00, 3'b100, 8'hFF, 0, 3'b100, 8'h20);
    tbl[6]  = mk(3'b010, 3'b000, 3'b000, 0, 8'hFF, 8'h00, 3'b010, 8'hFF, 0, 3'b010, 8'h08);
    tbl[7]  = mk(3'b000, 3'b000, 3'b000, 0, 8'hFF, 8'h00, 3'b000, 8'h00, 0, 3'b000, 8'h00);
    tbl[8]  = mk(3'b010, 3'b000, 3'b000, 0, 8'hFF, 8'h00, 3'b010, 8'hFF, 0, 3'b010, 8'h00);
    tbl[9]  = mk(3'b000, 3'b000, 3'b000, 0, 8'hF7, 8'h00, 3'b000, 8'h00, 0, 3'b000, 8'h00);
    tbl[10] = mk(3'b101, 3'b000, 3'b000, 1, 8'hFF, 8'h00, 3'b000, 8'h00, 0, 3'b000, 8'h00);
    tbl[11] = mk(3'b101, 3'b000, 3'b000, 1, 8'hFF, 8'h00, 3'b000, 8'h00, 0, 3'b000, 8'h00);
    tbl[12] = mk(3'b101, 3'b000, 3'b000, 1, 8'hFF, 8'h00, 3'b000, 8'h00, 0, 3'b000, 8'h00);
    tbl[13] = mk(3'b101, 3'b000, 3'b000, 0, 8'hFF, 8'h00, 3'b100, 8'hFF, 0, 3'b100, 8'h20);
    tbl[14] = mk(3'b000, 3'b000, 3'b000, 0, 8'hFF, 8'h00, 3'b000, 8'h00, 0, 3'b000, 8'h00);
    tbl[15] = mk(3'b001, 3'b001, 3'b000, 0, 8'hFF, 8'h04, 3'b001, 8'h04, 1, 3'b000, 8'h00);
    tbl[16] = mk(3'b000, 3'b000, 3'b000, 0, 8'hFF, 8'h00, 3'b000, 8'h00, 0, 3'b000, 8'h00);
    tbl[17] = mk(3'b100, 3'b000, 3'b000, 0, 8'hFF, 8'h00, 3'b100, 8'hFF, 0, 3'b000, 8'h00);
    tbl[18] = mk(3'b000, 3'b000, 3'b100, 0, 8'hFF, 8'h00, 3'b000, 8'h00, 0, 3'b000, 8'h00);
    tbl[19] = mk(3'b001, 3'b000, 3'b000, 0, 8'hFF, 8'h00, 3'b001, 8'hFF, 0, 3'b001, 8'h02);
    tbl[20] = mk(3'b001, 3'b000, 3'b000, 0, 8'hFF, 8'h00, 3'b001, 8'hFF, 0, 3'b001, 8'h02);
    tbl[21] = mk(3'b000, 3'b000, 3'b000, 0, 8'hFF, 8'h00, 3'b000, 8'h00, 0, 3'b000, 8'h00);
    tbl[22] = mk(3'b010, 3'b000, 3'b000, 0, 8'hFF, 8'h00, 3'b010, 8'hFF, 0, 3'b010, 8'h08);
    tbl[23] = mk(3'b010, 3'b000, 3'b000, 1, 8'hFF, 8'h00, 3'b000, 8'h00, 0, 3'b000, 8'h00);
    tbl[24] = mk(3'b000, 3'b000, 3'b000, 0, 8'hFF, 8'h00, 3'b000, 8'h00, 0, 3'b000, 8'h00);
    tbl[25] = mk(3'b010, 3'b000, 3'b000, 0, 8'hFF, 8'h00, 3'b010, 8'hFF, 0, 3'b010, 8'h08);
    tbl[26] = mk(3'b000, 3'b000, 3'b001, 0, 8'hFF, 8'h00, 3'b000, 8'h00, 0, 3'b000, 8'h00);

    // Port tags hit ways 1, 3 and 5 respectively; way 3 holds 0x5A
    addr = {12'h333, 12'h222, 12'h111};
    tag  = {44'h105, 44'h05A, 44'h101};
    for (int j = 0; j < SA; j++)
      sram_tag[j*TW +: TW] = (j == 3) ? 44'h05A : 44'(32'h100 + j);

    rst_n = 1'b0; req = 3'b111; we = '0; kill = '0; stall = 1'b0;
    sram_way = '0; sram_valid = 8'hFF;
    #12;
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_sram_req", 64'(sram_req), 64'h0);
    chk("rst_sram_addr", 64'(sram_addr), 64'h0);
    chk("rst_sram_we", 64'(sram_we), 64'h0);
    chk("rst_rvalid", 64'(rvalid), 64'h0);
    chk("rst_hit", 64'(hit), 64'h0);
    chk("rst_hit_way", 64'(hit_way), 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1; req = '0;

    for (int i = 0; i < 27; i++) run_cycle(tbl[i]);

    // Reset while a lookup is in flight: result discarded, pointer back to 0
    run_cycle(mk(3'b111, 3'b000, 3'b000, 0, 8'hFF, 8'h00, 3'b100, 8'hFF, 0, 3'b100, 8'h20));
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_gnt", 64'(gnt), 64'h0);
    chk("midrst_sram_req", 64'(sram_req), 64'h0);
    chk("midrst_rvalid", 64'(rvalid), 64'h0);
    sbq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1; req = '0;
    run_cycle(mk(3'b111, 3'b000, 3'b000, 0, 8'hFF, 8'h00, 3'b001, 8'hFF, 0, 3'b001, 8'h02));
    run_cycle(mk(3'b000, 3'b000, 3'b000, 0, 8'hFF, 8'h00, 3'b000, 8'h00, 0, 3'b000, 8'h00));

    if (sbq.size() != 0) chk("scoreboard_drained", 64'(sbq.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dcache_tag_arbiter.md
Name: dcache_tag_arbiter

Overview:
- Round-robin scheduler that shares one set-associative tag/data SRAM bank between NR_PORTS requesters (load unit, store unit, miss handler).
- Pipelined in two stages: S0 arbitrates and issues the SRAM access; S1 compares the late-arriving tag against the stored way tags and returns hit/miss to the winning port.
- Sits between the cache controllers and the SRAM bank, ahead of the miss unit.

Parameters:
- NR_PORTS, 3, number of requesters (2..8)
- ADDR_WIDTH, 12, SRAM index/offset address width
- TAG_WIDTH, 44, tag width
- SET_ASSOC, 8, number of ways

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  NR_PORTS  per-port request; held until gnt_o
- we_i  in  NR_PORTS  per-port write enable
- addr_i  in  NR_PORTS*ADDR_WIDTH  per-port address
- tag_i  in  NR_PORTS*TAG_WIDTH  per-port tag, valid one cycle after gnt_o
- kill_i  in  NR_PORTS  aborts that port's S1 lookup
- gnt_o  out  NR_PORTS  one-hot grant, combinational from S0
- rvalid_o  out  NR_PORTS  one-hot lookup result valid, from S1
- hit_o  out  1  lookup hit, qualified by rvalid_o
- hit_way_o  out  SET_ASSOC  one-hot hit way, qualified by rvalid_o
- stall_i  in  1  SRAM owned externally; no grant while high
- sram_req_o  out  SET_ASSOC  way enables (all ones for reads, single way for writes)
- sram_addr_o  out  ADDR_WIDTH  muxed address
- sram_we_o  out  1  muxed write enable
- sram_way_i  in  SET_ASSOC  write target way from the winning port (OR-reduced by the muxing)
- sram_tag_i  in  SET_ASSOC*TAG_WIDTH  stored tags, one cycle after sram_req_o
- sram_valid_i  in  SET_ASSOC  stored valid bits, one cycle after sram_req_o

Behaviour:
- Interface: one clock (clk_i). Reset is asynchronous and active-low (rst_ni).
- Reset values:
  - gnt_o, rvalid_o, hit_o, hit_way_o, sram_req_o, sram_addr_o and sram_we_o are 0.
  - RR pointer is 0; S1 valid is 0.
- S0 arbitration:
  - Search req_i starting at the RR pointer, wrapping modulo NR_PORTS; the first asserted port wins.
  - gnt_o is driven in the same cycle, together with the SRAM outputs for the winner.
  - When stall_i=1: gnt_o=0, sram_req_o=0.
- RR pointer: on a grant, pointer <= winner+1, wrapping to 0 after NR_PORTS-1. No grant leaves the pointer unchanged.
- Writes:
  - Complete in S0: sram_req_o = sram_way_i.
  - No S1 entry and no rvalid_o.
- Reads:
  - S1 registers the winner id (one-hot) and valid.
  - The next cycle compares the winner's tag_i with each way: hit_way_o[j] = (tag == sram_tag_i[j]) & sram_valid_i[j]; hit_o = |hit_way_o.
  - rvalid_o[id] = 1 for exactly one cycle. Fixed latency: rvalid exactly 1 cycle after gnt.
- Back-to-back: a new grant is allowed every cycle. S1 and S0 operate concurrently, so a port may see rvalid and a new gnt in the same cycle.
- kill_i[id] asserted during the S1 cycle: rvalid_o=0, hit_o=0. The result is dropped silently.
- Multi-hit: hit_way_o is passed through unchanged. A simulation-only assertion checks $onehot0(hit_way_o) whenever rvalid_o is nonzero.
- stall_i rising while S1 is valid: S1 still completes; only S0 is blocked.
- Reset mid-operation: S1 is discarded and the pointer returns to 0. No rvalid_o is emitted for the in-flight lookup.

Optional Feature:
- Macro: DCACHE_TAG_ARB_LOCK_EN.
- When defined:
  - Adds input lock_i[NR_PORTS].
  - A granted port with lock_i=1 keeps exclusive ownership and wins every subsequent cycle it requests, regardless of the RR pointer, until it is granted with lock_i=0. This is used for read-modify-write sequences.
  - The pointer does not advance while locked.
  - stall_i still overrides the lock.
- When undefined: pure round-robin; no lock_i port exists.

Test Plan:
- Reset, then ports 0,1,2 request continuously (reads) -> gnt order 0,1,2,0,1,2; each rvalid one cycle after its gnt.
- Port 1 read; next cycle tag_i[1]=0x5A and way 3 stores 0x5A with valid=1 -> rvalid_o=3'b010, hit_o=1, hit_way_o=8'h08.
- Same lookup with way 3 valid=0 -> hit_o=0, hit_way_o=0.
- stall_i=1 for 3 cycles while ports 0 and 2 request -> no gnt, pointer unchanged; after stall drops, port at pointer granted first.
- Port 0 write with sram_way_i=8'h04 -> sram_req_o=8'h04, sram_we_o=1, no rvalid; kill_i[2] during a port-2 S1 cycle -> rvalid_o=0.
- With DCACHE_TAG_ARB_LOCK_EN: port 2 locks for 4 cycles while ports 0 and 1 request -> port 2 granted 4 consecutive cycles, then port 0.
